// File: rtl/fifo_framer_skidbuffer.sv
// fifo_framer_skidbuffer -- two-entry skid buffer with a registered ready.
//
// Holds an output word plus one spare (skid) word. The upstream ready
// (!skid_full) comes straight from a register, so the producer never sees a
// combinational path from the downstream ready. Occupancy is encoded by the two
// valid bits {out_valid, skid_valid}: 00 empty, 10 one word, 11 full; 01 is
// never entered because the skid only fills while the output is stalled.
//
// Ports
//    clk        in   1    system clock
//    reset      in   1    synchronous, active-high; discards both words
//    load       in   1    accept load_data this cycle (only while !skid_full)
//    load_data  in   BW   incoming word
//    skid_full  out  1    spare entry occupied; producer must not load
//    valid      out  1    data holds a word
//    ready      in   1    downstream takes the word this cycle
//    data       out  BW   output word, stable while valid && !ready
module fifo_framer_skidbuffer #(
   parameter int BW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [BW-1:0] load_data,
   output logic          skid_full,
   output logic          valid,
   input  logic          ready,
   output logic [BW-1:0] data
);
   logic          out_valid_reg,  out_valid_next;
   logic          skid_valid_reg, skid_valid_next;
   logic [BW-1:0] out_data_reg,   out_data_next;
   logic [BW-1:0] skid_data_reg,  skid_data_next;

   assign skid_full = skid_valid_reg;
   assign valid     = out_valid_reg;
   assign data      = out_data_reg;

   always_comb begin
      out_valid_next  = out_valid_reg;
      skid_valid_next = skid_valid_reg;
      out_data_next   = out_data_reg;
      skid_data_next  = skid_data_reg;
      if (!out_valid_reg || ready) begin
         // Output slot frees up: the skid word has priority, it is older.
         if (skid_valid_reg) begin
            out_data_next   = skid_data_reg;
            out_valid_next  = 1'b1;
            skid_valid_next = 1'b0;
         end else if (load) begin
            out_data_next   = load_data;
            out_valid_next  = 1'b1;
         end else begin
            out_valid_next  = 1'b0;
         end
      end else if (load) begin
         // Output stalled: park the new word in the skid.
         skid_data_next  = load_data;
         skid_valid_next = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_reg  <= 1'b0;
         skid_valid_reg <= 1'b0;
         out_data_reg   <= '0;
         skid_data_reg  <= '0;
      end else begin
         out_valid_reg  <= out_valid_next;
         skid_valid_reg <= skid_valid_next;
         out_data_reg   <= out_data_next;
         skid_data_reg  <= skid_data_next;
      end
   end
endmodule

// File: rtl/sfifo.sv
// sfifo -- synchronous sample FIFO with a first-word-fall-through read port.
//
// The head word is always visible on o_data while o_empty is low; a pop
// (i_rd) advances to the next word on the following clock. Writes while full
// and reads while empty are dropped and latch the sticky o_err flag.
//
// Ports
//    i_clk     in   1          system clock
//    i_reset   in   1          synchronous, active-high reset
//    i_wr      in   1          push i_data (ignored when full)
//    i_data    in   BW         word to push
//    o_full    out  1          FIFO holds 2^LGFLEN words
//    o_fill    out  LGFLEN+1   number of stored words
//    i_rd      in   1          pop the head word (ignored when empty)
//    o_data    out  BW         head word, valid while o_empty==0
//    o_empty   out  1          FIFO holds no words
//    o_err     out  1          sticky overflow/underflow flag
module sfifo #(
   parameter int BW     = 8,
   parameter int LGFLEN = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_wr,
   input  logic [BW-1:0]     i_data,
   output logic              o_full,
   output logic [LGFLEN:0]   o_fill,
   input  logic              i_rd,
   output logic [BW-1:0]     o_data,
   output logic              o_empty,
   output logic              o_err
);
   localparam int DEPTH = 1 << LGFLEN;

   logic [BW-1:0]   mem [DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [LGFLEN:0] wr_ptr_reg;
   logic [LGFLEN:0] rd_ptr_reg;
   logic            err_reg;
   logic            do_wr;
   logic            do_rd;

   assign o_fill  = wr_ptr_reg - rd_ptr_reg;
   assign o_full  = (o_fill == (LGFLEN+1)'(DEPTH));
   assign o_empty = (o_fill == '0);
   assign o_err   = err_reg;
   assign do_wr   = i_wr && !o_full;
   assign do_rd   = i_rd && !o_empty;

   // Fall-through read: the head word is presented without a read request.
   assign o_data = mem[rd_ptr_reg[LGFLEN-1:0]];

   always_ff @(posedge i_clk) begin
      if (do_wr)
         mem[wr_ptr_reg[LGFLEN-1:0]] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         if (do_wr)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_rd)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         if ((i_wr && o_full) || (i_rd && o_empty))
            err_reg <= 1'b1;
      end
   end
endmodule

// File: rtl/fifo_framer.sv
// fifo_framer -- drains a first-word-fall-through FIFO into a valid/ready
// stream and marks the last word of every 2^LGFRAME-word frame.
//
// Pops are requested only when the FIFO is non-empty and the skid buffer has a
// free spare entry, so the request never depends on i_ready and the FIFO can
// never underflow. FIFO errors are latched into a sticky o_err that does not
// stall the stream.
//
// Ports
//    i_clk         in   1      system clock
//    i_reset       in   1      synchronous, active-high reset
//    i_fifo_data   in   BW     FIFO head word
//    i_fifo_empty  in   1      FIFO empty flag
//    i_fifo_err    in   1      FIFO sticky error flag
//    o_fifo_rd     out  1      pop request to the FIFO
//    o_valid       out  1      output word valid
//    i_ready       in   1      downstream accepts the word
//    o_data        out  BW     output word
//    o_last        out  1      o_data is the last word of its frame
//    o_frames      out  LGCNT  completed frames, wrapping
//    o_err         out  1      sticky error
module fifo_framer #(
   parameter int BW      = 8,
   parameter int LGFRAME = 10,
   parameter int LGCNT   = 16
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [BW-1:0]    i_fifo_data,
   input  logic             i_fifo_empty,
   input  logic             i_fifo_err,
   output logic             o_fifo_rd,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [BW-1:0]    o_data,
   output logic             o_last,
   output logic [LGCNT-1:0] o_frames,
   output logic             o_err
);
   localparam int                   FRAME    = 1 << LGFRAME;
   localparam logic [LGFRAME-1:0]   LAST_IDX = LGFRAME'(FRAME - 1);

   logic               skid_full;
   logic               complete;
   logic [LGFRAME-1:0] count_reg;
   logic [LGCNT-1:0]   frames_reg;
   logic               err_reg;

   assign o_fifo_rd = !i_reset && !i_fifo_empty && !skid_full;
   assign complete  = o_valid && i_ready;
   assign o_last    = o_valid && (count_reg == LAST_IDX);
   assign o_frames  = frames_reg;
   assign o_err     = err_reg;

   fifo_framer_skidbuffer #(.BW(BW)) u_skid (
      .clk       (i_clk),
      .reset     (i_reset),
      .load      (o_fifo_rd),
      .load_data (i_fifo_data),
      .skid_full (skid_full),
      .valid     (o_valid),
      .ready     (i_ready),
      .data      (o_data)
   );

   // count_reg is the index of the word currently on o_data within its frame;
   // it wraps naturally at FRAME because it is exactly LGFRAME bits wide.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count_reg  <= '0;
         frames_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         if (complete) begin
            count_reg <= count_reg + 1'b1;
            if (o_last)
               frames_reg <= frames_reg + LGCNT'(1);
         end
         if (i_fifo_err)
            err_reg <= 1'b1;
      end
   end
endmodule

// File: tb/tb_fifo_framer.sv
// tb_fifo_framer -- sfifo (BW=8, LGFLEN=4) feeding fifo_framer (LGFRAME=2).
// A queue-level model of the words held by the framer, a scoreboard of every
// word accepted by the FIFO, and frame arithmetic are checked on every cycle;
// each directed test then pins the model with hand-computed literals.
module tb_fifo_framer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr = 1'b0;
   logic        ready = 1'b0;
   logic [7:0]  wdata = 8'h00;
   logic        fifo_full, fifo_empty, fifo_err, fifo_rd;
   logic [4:0]  fifo_fill;
   logic [7:0]  fifo_data, data;
   logic        valid, last, err;
   logic [15:0] frames;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sfifo #(.BW(8), .LGFLEN(4)) u_fifo (
      .i_clk(clk), .i_reset(reset), .i_wr(wr), .i_data(wdata),
      .o_full(fifo_full), .o_fill(fifo_fill), .i_rd(fifo_rd),
      .o_data(fifo_data), .o_empty(fifo_empty), .o_err(fifo_err)
   );

   fifo_framer #(.BW(8), .LGFRAME(2), .LGCNT(16)) dut (
      .i_clk(clk), .i_reset(reset), .i_fifo_data(fifo_data),
      .i_fifo_empty(fifo_empty), .i_fifo_err(fifo_err), .o_fifo_rd(fifo_rd),
      .o_valid(valid), .i_ready(ready), .o_data(data), .o_last(last),
      .o_frames(frames), .o_err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: words the framer holds (oldest first), words accepted by
   // the FIFO not yet delivered, frame position and counters.
   logic [7:0] held[$];
   logic [7:0] sb[$];
   int         m_cnt = 0;
   int         m_frames = 0;
   bit         m_err = 1'b0;
   bit         m_comp, m_pop;
   bit         mon_on = 1'b0;
   logic [8:0] log_q[$];      // {last, data} of each completed word
   int         log_cyc[$];
   int         cyc = 0;
   int         act_pops = 0, rd_empty_hits = 0, valid_hits = 0;

   always @(negedge clk) begin
      if (mon_on) begin
         cyc++;
         chk("o_valid", valid, held.size() > 0);
         if (held.size() > 0) begin
            chk("o_data", data, held[0]);
            chk("o_last", last, m_cnt == 3);
         end else begin
            chk("o_last_idle", last, 0);
         end
         chk("o_frames", frames, m_frames[15:0]);
         chk("o_err", err, m_err);
         chk("o_fifo_rd", fifo_rd, !reset && !fifo_empty && held.size() < 2);
         chk("skid_only_state", dut.u_skid.skid_valid_reg && !valid, 0);
         if (fifo_rd) act_pops++;
         if (fifo_rd && fifo_empty) rd_empty_hits++;
         if (valid) valid_hits++;
         if (!reset && valid && ready) begin
            log_q.push_back({last, data});
            log_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_order: got %02h expected no word", data);
            end else begin
               chk("sb_order", data, sb.pop_front());
            end
         end
         // Advance the model to the state after the coming rising edge.
         if (reset) begin
            held.delete();
            sb.delete();
            m_cnt = 0;
            m_frames = 0;
            m_err = 1'b0;
         end else begin
            m_comp = held.size() > 0 && ready;
            m_pop  = !fifo_empty && held.size() < 2;
            if (m_comp) begin
               if (m_cnt == 3) m_frames++;
               m_cnt = (m_cnt + 1) % 4;
               void'(held.pop_front());
            end
            if (m_pop) held.push_back(fifo_data);
            if (fifo_err) m_err = 1'b1;
            if (wr && !fifo_full) sb.push_back(wdata);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      wr = 1'b1;
      wdata = d;
      tick(1);
      wr = 1'b0;
   endtask

   task automatic clear_log();
      log_q.delete();
      log_cyc.delete();
   endtask

   // Check that the log holds n words base, base+1, ... with o_last on every 4th.
   task automatic chk_log(input string name, input int n, input logic [7:0] base);
      logic [7:0] e;
      chk({name, "_count"}, log_q.size(), n);
      for (int i = 0; i < log_q.size() && i < n; i++) begin
         e = base + 8'(i);
         chk({name, "_data"}, log_q[i][7:0], e);
         chk({name, "_last"}, log_q[i][8], (i % 4) == 3);
      end
   endtask

   int nwr;
   int bad_last;

   initial begin
      tick(1);
      mon_on = 1'b1;
      chk("rst_valid", valid, 0);
      chk("rst_data", data, 0);
      chk("rst_last", last, 0);
      chk("rst_frames", frames, 0);
      chk("rst_err", err, 0);
      chk("rst_fifo_rd", fifo_rd, 0);

      // 1: eight words streamed with ready held high.
      do_reset();
      ready = 1'b1;
      clear_log();
      for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
      tick(6);
      chk_log("t1", 8, 8'h10);
      if (log_cyc.size() == 8) chk("t1_back_to_back", log_cyc[7] - log_cyc[0], 7);
      chk("t1_frames", frames, 2);
      chk("t1_fifo_err", fifo_err, 0);

      // 2: stalled output takes exactly two words, then drains back-to-back.
      do_reset();
      ready = 1'b0;
      clear_log();
      act_pops = 0;
      for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
      tick(10);
      chk("t2_pops", act_pops, 2);
      chk("t2_valid", valid, 1);
      chk("t2_hold_data", data, 8'h10);
      chk("t2_fifo_fill", fifo_fill, 2);
      ready = 1'b1;
      tick(8);
      chk_log("t2", 4, 8'h10);
      if (log_cyc.size() == 4) chk("t2_back_to_back", log_cyc[3] - log_cyc[0], 3);

      // 3: empty FIFO with random ready.
      do_reset();
      rd_empty_hits = 0;
      valid_hits = 0;
      repeat (200) begin
         ready = 1'($urandom_range(0, 1));
         tick(1);
      end
      chk("t3_rd_while_empty", rd_empty_hits, 0);
      chk("t3_valid_seen", valid_hits, 0);
      chk("t3_fifo_err", fifo_err, 0);

      // 4: two words sit in the framer, 16 fill the FIFO, the 19th overflows.
      do_reset();
      ready = 1'b0;
      clear_log();
      for (int i = 0; i < 18; i++) push(8'(i));
      chk("t4_full", fifo_full, 1);
      chk("t4_no_err_yet", fifo_err, 0);
      push(8'hEE);
      chk("t4_fifo_err", fifo_err, 1);
      chk("t4_err_delay", err, 0);
      tick(1);
      chk("t4_err", err, 1);
      ready = 1'b1;
      tick(25);
      chk_log("t4", 18, 8'h00);
      chk("t4_err_sticky", err, 1);

      // 5: reset right after the second word of a frame.
      do_reset();
      ready = 1'b1;
      clear_log();
      for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
      for (int i = 0; i < 50 && log_q.size() < 2; i++) tick(1);
      chk("t5_reset_point", log_q.size(), 2);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      chk("t5_flush_valid", valid, 0);
      chk("t5_flush_frames", frames, 0);
      clear_log();
      for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
      tick(6);
      chk_log("t5", 4, 8'hA0);
      chk("t5_frames", frames, 1);

      // 6: random traffic against the scoreboard.
      do_reset();
      clear_log();
      nwr = 0;
      repeat (10000) begin
         wr = ($urandom_range(0, 1) == 1) && !fifo_full;
         wdata = 8'($urandom);
         ready = ($urandom_range(0, 3) != 0);
         if (wr) nwr++;
         tick(1);
      end
      wr = 1'b0;
      ready = 1'b1;
      tick(40);
      chk("t6_drained", sb.size(), 0);
      chk("t6_count", log_q.size(), nwr);
      bad_last = 0;
      for (int i = 0; i < log_q.size(); i++)
         if (log_q[i][8] != ((i % 4) == 3)) bad_last++;
      chk("t6_last_every_4th", bad_last, 0);
      chk("t6_frames", frames, (nwr / 4) % 65536);
      chk("t6_err", err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
